gray_seq_checker: RTL and testbench
===================================

GRAY_SEQ_CHECKER -- requirements
Module: gray_seq_checker

Interface
REQ-001 Parameter WIDTH, default 4: width of the Gray code word and the decoded binary word.
REQ-002 Parameter ERR_W, default 8: width of the error counter.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port gray_valid, input, 1: gray_code is sampled this cycle.
REQ-006 Port gray_code, input, WIDTH: Gray-coded word produced by the upstream binary-to-Gray converter.
REQ-007 Port clear, input, 1: synchronous soft clear of tracking state and error count.
REQ-008 Port bin_out, output, WIDTH: registered binary decode of the last accepted sample.
REQ-009 Port bin_valid, output, 1: one-cycle pulse; bin_out was updated this cycle.
REQ-010 Port step_up, output, 1: one-cycle pulse; accepted sample equals previous binary +1 mod 2^WIDTH.
REQ-011 Port step_down, output, 1: one-cycle pulse; accepted sample equals previous binary -1 mod 2^WIDTH.
REQ-012 Port seq_error, output, 1: one-cycle pulse; accepted sample differs from the previous code in more than one bit.
REQ-013 Port err_count, output, ERR_W: saturating count of seq_error events.
REQ-014 Port locked, output, 1: a reference sample is held (FSM in TRACK).

Function
REQ-015 Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] XOR g[i]; the decode is purely combinational before the output register.
REQ-016 Latency: a sample with gray_valid=1 in cycle N appears on bin_out/bin_valid and on the step and error flags in cycle N+1.
REQ-017 FSM states: UNLOCKED (no reference) and TRACK (reference code held in prev_gray).
REQ-018 UNLOCKED + gray_valid: store prev_gray, update bin_out, pulse bin_valid, move to TRACK; step_up, step_down and seq_error stay 0.
REQ-019 TRACK + gray_valid, Hamming distance 0: bin_valid pulses; no step and no error pulse.
REQ-020 TRACK + gray_valid, Hamming distance 1: pulse step_up or step_down by binary comparison mod 2^WIDTH; wrap 15->0 is step_up and 0->15 is step_down (WIDTH=4).
REQ-021 TRACK + gray_valid, Hamming distance >1: pulse seq_error, increment err_count, resynchronise prev_gray and bin_out to the new sample, stay in TRACK.
REQ-022 err_count saturates at 2^ERR_W-1; further errors still pulse seq_error.
REQ-023 gray_valid=0: all pulse outputs 0; bin_out, prev_gray, state and err_count hold.
REQ-024 clear=1: state goes to UNLOCKED, err_count goes to 0, and all pulses go to 0; bin_out holds its value.
REQ-025 clear and gray_valid in the same cycle: clear wins and the sample is dropped.
REQ-026 step_up, step_down and seq_error are mutually exclusive in every cycle.

Reset
REQ-027 rst_n=0 at a clock edge forces state UNLOCKED and sets bin_out, prev_gray, bin_valid, step_up, step_down, seq_error, err_count and locked to 0.
REQ-028 Reset overrides clear and gray_valid; a reset during TRACK discards the reference, and the next sample is treated as the first.

Structure
REQ-029 Shared package gray_pkg holds the default WIDTH and ERR_W and the FSM state encoding (UNLOCKED=0, TRACK=1).
REQ-030 Sub-module gray_to_bin, combinational and parameterised by WIDTH, implements REQ-015 and is reusable by other Gray consumers.

Verification
REQ-031 Reset: hold rst_n=0 for 2 cycles -> all outputs 0, locked=0.
REQ-032 Up count: samples 0000, 0001, 0011, 0010 -> bin_out 0, 1, 2, 3 on successive cycles; step_up on samples 2-4; err_count=0.
REQ-033 Wrap: 1000 then 0000 -> bin_out 15 then 0, one step_up; then 1000 -> step_down, no seq_error.
REQ-034 Jump: 0001 then 0111 -> seq_error for 1 cycle, err_count=1, bin_out=5; then 0101 -> step_up, bin_out=6.
REQ-035 Repeat and idle: 0011 twice with 3 idle cycles between -> bin_valid twice, no step and no error pulses, bin_out=2 throughout.
REQ-036 Saturation and clear: 260 alternating 0000/0011 samples -> err_count=255; then clear together with gray_valid -> err_count=0, locked=0, no bin_valid.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray sequence checker slice.
// Holds default widths and the tracking FSM state encoding.
package gray_pkg;

    localparam int GRAY_WIDTH = 4;
    localparam int GRAY_ERR_W = 8;

    typedef enum logic {
        UNLOCKED = 1'b0,
        TRACK    = 1'b1
    } gray_state_t;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder, reusable by any Gray consumer.
// Ports: gray (Gray word in), bin (binary word out), both WIDTH bits.
module gray_to_bin #(
    parameter int WIDTH = gray_pkg::GRAY_WIDTH
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Running XOR from the MSB down; a local accumulator avoids
    // a self-referencing vector inside the combinational block.
    always_comb begin
        logic acc;
        acc = 1'b0;
        bin = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end

endmodule

// File: rtl/gray_seq_checker.sv
// Tracks a Gray-coded stream, decodes it and flags unit steps and
// multi-bit jumps. Ports: clk, rst_n (sync, active-low), gray_valid,
// gray_code, clear in; bin_out, bin_valid, step_up, step_down,
// seq_error, err_count, locked out (all registered).
module gray_seq_checker #(
    parameter int WIDTH = gray_pkg::GRAY_WIDTH,
    parameter int ERR_W = gray_pkg::GRAY_ERR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gray_valid,
    input  logic [WIDTH-1:0] gray_code,
    input  logic             clear,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             step_up,
    output logic             step_down,
    output logic             seq_error,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);

    import gray_pkg::*;

    gray_state_t      state;
    logic [WIDTH-1:0] prev_gray;
    logic [WIDTH-1:0] dec_bin;
    logic [WIDTH-1:0] diff;
    logic             one_bit;
    logic             multi_bit;
    logic             is_up;
    logic             is_down;
    logic             cnt_full;

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_dec (
        .gray (gray_code),
        .bin  (dec_bin)
    );

    // A single set bit in diff means Hamming distance one.
    assign diff      = gray_code ^ prev_gray;
    assign one_bit   = (diff != '0) &&
                       ((diff & (diff - WIDTH'(1))) == '0);
    assign multi_bit = (diff != '0) && !one_bit;

    // bin_out always mirrors prev_gray while in TRACK, so it serves
    // as the previous binary value for direction detection.
    assign is_up     = (dec_bin == bin_out + WIDTH'(1));
    assign is_down   = (dec_bin == bin_out - WIDTH'(1));
    assign cnt_full  = (err_count == {ERR_W{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= UNLOCKED;
            prev_gray <= '0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            seq_error <= 1'b0;
            err_count <= '0;
            locked    <= 1'b0;
        end else begin
            bin_valid <= 1'b0;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            seq_error <= 1'b0;
            if (clear) begin
                state     <= UNLOCKED;
                locked    <= 1'b0;
                err_count <= '0;
            end else if (gray_valid) begin
                bin_valid <= 1'b1;
                bin_out   <= dec_bin;
                prev_gray <= gray_code;
                state     <= TRACK;
                locked    <= 1'b1;
                case (state)
                    UNLOCKED: begin
                    end
                    TRACK: begin
                        if (multi_bit) begin
                            seq_error <= 1'b1;
                            if (!cnt_full)
                                err_count <= err_count + ERR_W'(1);
                        end else if (one_bit) begin
                            // Up wins the tie that only exists at WIDTH=1.
                            if (is_up)
                                step_up <= 1'b1;
                            else if (is_down)
                                step_down <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_seq_checker.sv
// Scoreboard bench for gray_seq_checker.
// Drives directed and random streams and checks every output each cycle.
module tb_gray_seq_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       gray_valid;
    logic [3:0] gray_code;
    logic       clear;
    logic [3:0] bin_out;
    logic       bin_valid;
    logic       step_up;
    logic       step_down;
    logic       seq_error;
    logic [7:0] err_count;
    logic       locked;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] bin;
        logic       vld;
        logic       up;
        logic       dn;
        logic       err;
        logic [7:0] cnt;
        logic       lock;
    } exp_t;

    exp_t sb[$];

    logic       m_locked = 1'b0;
    logic [3:0] m_prev   = '0;
    logic [3:0] m_bin    = '0;
    logic [7:0] m_cnt    = '0;

    gray_seq_checker #(
        .WIDTH (4),
        .ERR_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_valid (gray_valid),
        .gray_code  (gray_code),
        .clear      (clear),
        .bin_out    (bin_out),
        .bin_valid  (bin_valid),
        .step_up    (step_up),
        .step_down  (step_down),
        .seq_error  (seq_error),
        .err_count  (err_count),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        for (int i = 0; i < 4; i++)
            b[i] = ^(g >> i);
        return b;
    endfunction

    // One clock of stimulus: model the expected outputs, push them,
    // clock the DUT, then pop and compare.
    task automatic cyc(input logic r, input logic v,
                       input logic [3:0] g, input logic c);
        exp_t e;
        exp_t o;
        logic [3:0] nb;
        int d;
        rst_n = r;
        gray_valid = v;
        gray_code = g;
        clear = c;
        e.vld = 1'b0;
        e.up  = 1'b0;
        e.dn  = 1'b0;
        e.err = 1'b0;
        if (!r) begin
            m_locked = 1'b0;
            m_bin    = '0;
            m_prev   = '0;
            m_cnt    = '0;
        end else if (c) begin
            m_locked = 1'b0;
            m_cnt    = '0;
        end else if (v) begin
            nb = g2b(g);
            e.vld = 1'b1;
            if (m_locked) begin
                d = $countones(g ^ m_prev);
                if (d > 1) begin
                    e.err = 1'b1;
                    if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
                end else if (d == 1) begin
                    e.up = (nb == 4'(m_bin + 4'd1));
                    e.dn = (nb == 4'(m_bin - 4'd1));
                end
            end
            m_locked = 1'b1;
            m_prev   = g;
            m_bin    = nb;
        end
        e.bin  = m_bin;
        e.cnt  = m_cnt;
        e.lock = m_locked;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check("bin_out",   int'(bin_out),   int'(o.bin));
        check("bin_valid", int'(bin_valid), int'(o.vld));
        check("step_up",   int'(step_up),   int'(o.up));
        check("step_down", int'(step_down), int'(o.dn));
        check("seq_error", int'(seq_error), int'(o.err));
        check("err_count", int'(err_count), int'(o.cnt));
        check("locked",    int'(locked),    int'(o.lock));
        check("exclusive",
              int'($countones({step_up, step_down, seq_error}) <= 1), 1);
    endtask

    task automatic smp(input logic [3:0] g);
        cyc(1'b1, 1'b1, g, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic clr();
        cyc(1'b1, 1'b0, 4'h0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        gray_valid = 1'b0;
        gray_code = '0;
        clear = 1'b0;

        // Reset held two cycles
        cyc(1'b0, 1'b1, 4'b0110, 1'b1);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0);
        check("rst_locked", int'(locked), 0);
        check("rst_bin", int'(bin_out), 0);

        // Up count
        smp(4'b0000);
        smp(4'b0001);
        smp(4'b0011);
        smp(4'b0010);
        check("up_bin3", int'(bin_out), 3);
        check("up_cnt", int'(err_count), 0);

        // Wrap both directions
        clr();
        smp(4'b1000);
        check("wrap_15", int'(bin_out), 15);
        smp(4'b0000);
        check("wrap_up", int'(step_up), 1);
        smp(4'b1000);
        check("wrap_dn", int'(step_down), 1);

        // Jump with resync
        clr();
        smp(4'b0001);
        smp(4'b0111);
        check("jump_err", int'(seq_error), 1);
        check("jump_bin", int'(bin_out), 5);
        smp(4'b0101);
        check("resync_up", int'(step_up), 1);
        check("resync_bin", int'(bin_out), 6);
        idle();
        check("err_hold", int'(err_count), 1);

        // Repeat around idle cycles
        smp(4'b0011);
        idle();
        idle();
        idle();
        smp(4'b0011);
        check("rep_bin", int'(bin_out), 2);

        // Reset in TRACK drops the reference
        smp(4'b0111);
        cyc(1'b0, 1'b1, 4'b0111, 1'b0);
        smp(4'b1111);
        check("post_rst_err", int'(seq_error), 0);

        // Saturation then clear beating a sample
        clr();
        for (int i = 0; i < 260; i++)
            smp((i % 2) ? 4'b0011 : 4'b0000);
        check("sat", int'(err_count), 255);
        smp(4'b0000);
        check("sat_pulse", int'(seq_error), 1);
        cyc(1'b1, 1'b1, 4'b0011, 1'b1);
        check("clr_cnt", int'(err_count), 0);
        check("clr_lock", int'(locked), 0);
        check("clr_vld", int'(bin_valid), 0);

        // Random mix
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) != 0),
                ($urandom_range(0, 3) != 0),
                4'($urandom_range(0, 15)),
                ($urandom_range(0, 29) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
